mac_acc_seq: RTL and testbench

Parametrised, length-controlled multiply-accumulate engine. It is the successor to the fixed 16-bit free-running MAC.
- Accepts a burst of LEN operand pairs over a valid/ready stream.
- Multiplies each pair and accumulates the products in a 2-stage pipeline.
- Returns one N-bit result with a sticky overflow flag over a valid/ready output.
- Wrap or saturate mode; unsigned or two's-complement.
- Sits between the operand feeder and the result collector in the garbled-circuit test-generator datapath.

---
 rtl/mac_acc_seq.sv | 156 +++++++++++++++
 tb/tb_mac_acc_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_seq.sv
// Length-controlled multiply-accumulate engine: accepts LEN operand pairs, accumulates
// products through a 2-stage pipeline and returns one N-bit result with a sticky overflow flag.
module mac_acc_seq #(
    parameter int unsigned N      = 16,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned SAT    = 0,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [N-1:0]     g_input,
    input  logic [N-1:0]     e_input,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned PW = 2 * N;
    localparam logic [N-1:0] HI_BOUND = (SIGNED != 0) ? {1'b0, {(N-1){1'b1}}} : {N{1'b1}};
    localparam logic [N-1:0] LO_BOUND = (SIGNED != 0) ? {1'b1, {(N-1){1'b0}}} : {N{1'b0}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] retired;
    logic [N-1:0]     acc;
    logic [PW-1:0]    prod;
    logic             prod_valid;

    logic             accept;
    logic             start_go;
    logic             finish;
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [PW-1:0]    prod_c;
    logic             p_fits;
    logic [N-1:0]     term;
    logic [N:0]       sum;
    logic             s_fits;
    logic [N-1:0]     acc_nx;
    logic             step_ovf;

    assign in_ready = (state == ACC) && (issued < len_q);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign start_go = (state == IDLE) && start;
    assign finish   = (state == ACC) && (retired == len_q);

    // Stage-1 operand extension; the low 2N bits of the product are exact for both signednesses
    always_comb begin
        a_ext = {{N{1'b0}}, g_input};
        b_ext = {{N{1'b0}}, e_input};
        if (SIGNED != 0) begin
            a_ext = {{N{g_input[N-1]}}, g_input};
            b_ext = {{N{e_input[N-1]}}, e_input};
        end
        prod_c = a_ext * b_ext;
    end

    // Stage-2 range check and wrap/clamp of the product, then of the running sum
    always_comb begin
        if (SIGNED != 0) begin
            p_fits = (&prod[PW-1:N-1]) || ~(|prod[PW-1:N-1]);
        end else begin
            p_fits = ~(|prod[PW-1:N]);
        end
        term = prod[N-1:0];
        if (!p_fits && (SAT != 0)) begin
            term = (SIGNED != 0 && prod[PW-1]) ? LO_BOUND : HI_BOUND;
        end
        if (SIGNED != 0) begin
            sum    = {acc[N-1], acc} + {term[N-1], term};
            s_fits = (sum[N] == sum[N-1]);
        end else begin
            sum    = {1'b0, acc} + {1'b0, term};
            s_fits = !sum[N];
        end
        acc_nx = sum[N-1:0];
        if (!s_fits && (SAT != 0)) begin
            acc_nx = (SIGNED != 0 && sum[N]) ? LO_BOUND : HI_BOUND;
        end
        step_ovf = !p_fits || !s_fits;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (len == '0) ? DONE : ACC;
            ACC:  if (finish) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            issued     <= '0;
            retired    <= '0;
            acc        <= '0;
            prod       <= '0;
            prod_valid <= 1'b0;
            o          <= '0;
            out_valid  <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            prod_valid <= accept;
            if (accept) begin
                prod   <= prod_c;
                issued <= issued + LEN_W'(1);
            end
            if (prod_valid) begin
                acc     <= acc_nx;
                ovf     <= ovf | step_ovf;
                retired <= retired + LEN_W'(1);
            end
            if (start_go) begin
                len_q      <= len;
                acc        <= '0;
                ovf        <= 1'b0;
                issued     <= '0;
                retired    <= '0;
                prod_valid <= 1'b0;
                if (len == '0) begin
                    o         <= '0;
                    out_valid <= 1'b1;
                end
            end
            if (finish) begin
                o         <= acc;
                out_valid <= 1'b1;
            end
            if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_acc_seq.sv
// Self-checking bench for mac_acc_seq: four configurations (wrap/sat x unsigned/signed) share one
// stimulus stream and are checked every cycle against a burst-level arithmetic model.
module tb_mac_acc_seq;

    localparam int unsigned N     = 16;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned NCFG  = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [N-1:0]     g_in;
    logic [N-1:0]     e_in;
    logic             in_valid;
    logic             out_ready;

    logic [N-1:0] o_w    [NCFG];
    logic         ov_w   [NCFG];
    logic         ovf_w  [NCFG];
    logic         rdy_w  [NCFG];
    logic         busy_w [NCFG];

    // Config index k: SAT = k/2, SIGNED = k%2
    for (genvar k = 0; k < NCFG; k++) begin : g_dut
        mac_acc_seq #(.N(N), .LEN_W(LEN_W), .SAT(k / 2), .SIGNED(k % 2)) u_dut (
            .clk(clk), .rst(rst), .start(start), .len(len),
            .g_input(g_in), .e_input(e_in), .in_valid(in_valid), .in_ready(rdy_w[k]),
            .o(o_w[k]), .out_valid(ov_w[k]), .out_ready(out_ready),
            .ovf(ovf_w[k]), .busy(busy_w[k])
        );
    end

    int           n_assert;
    int           n_fail;
    bit           running;
    bit           m_busy;
    bit           m_acc;
    bit           m_ov;
    int           m_issued;
    int           m_len;
    logic [N-1:0] m_o     [NCFG];
    logic [N-1:0] exp_res [NCFG];
    logic         exp_ovf [NCFG];
    int           pa [256];
    int           pb [256];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cfg%0d actual=%0h required=%0h at %0t", nm, k, act, req, $time);
        end
    endtask

    function automatic longint opval(input int bits, input bit sgn);
        if (sgn && bits >= (1 << (N - 1))) return longint'(bits) - (longint'(1) << N);
        return longint'(bits);
    endfunction

    function automatic longint limit(input longint x, input longint lo, input longint hi,
                                     input bit sat, input bit sgn);
        longint w;
        if (sat) return (x < lo) ? lo : hi;
        w = x & ((longint'(1) << N) - 1);
        if (sgn && w > hi) w = w - (longint'(1) << N);
        return w;
    endfunction

    // Reference result of the current burst (pa/pb[0..L-1]) for configuration cfg
    function automatic void model(input int cfg, input int L, output logic [N-1:0] res, output logic of);
        bit     sat = (cfg / 2) != 0;
        bit     sgn = (cfg % 2) != 0;
        longint lo  = sgn ? -(longint'(1) << (N - 1)) : 0;
        longint hi  = sgn ? (longint'(1) << (N - 1)) - 1 : (longint'(1) << N) - 1;
        longint acc = 0;
        longint p;
        of = 1'b0;
        for (int i = 0; i < L; i++) begin
            p = opval(pa[i], sgn) * opval(pb[i], sgn);
            if (p < lo || p > hi) begin of = 1'b1; p = limit(p, lo, hi, sat, sgn); end
            acc = acc + p;
            if (acc < lo || acc > hi) begin of = 1'b1; acc = limit(acc, lo, hi, sat, sgn); end
        end
        res = N'(acc);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one burst; returns with all DUTs expected in DONE
    task automatic run_burst(input int L, input int gaps);
        int gap_run = 0;
        bit v;
        for (int k = 0; k < NCFG; k++) model(k, L, exp_res[k], exp_ovf[k]);
        start = 1'b1;
        len   = LEN_W'(L);
        tick;
        start    = 1'b0;
        m_busy   = 1'b1;
        m_len    = L;
        m_issued = 0;
        if (L == 0) begin
            m_ov = 1'b1;
            for (int k = 0; k < NCFG; k++) m_o[k] = exp_res[k];
            return;
        end
        m_acc = 1'b1;
        while (m_issued < L) begin
            if (gaps == 0) v = 1'b1;
            else if (gaps == 2) v = (gap_run >= 2);
            else v = ($urandom_range(0, 2) != 0) || (gap_run >= 3);
            gap_run  = v ? 0 : gap_run + 1;
            in_valid = v;
            g_in     = v ? N'(pa[m_issued]) : N'($urandom);
            e_in     = v ? N'(pb[m_issued]) : N'($urandom);
            start    = ($urandom_range(0, 3) == 0);
            len      = LEN_W'($urandom);
            tick;
            if (v) m_issued++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        tick;
        tick;
        m_acc = 1'b0;
        m_ov  = 1'b1;
        for (int k = 0; k < NCFG; k++) m_o[k] = exp_res[k];
    endtask

    task automatic take_result(input int hold);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            start     = $urandom_range(0, 1) != 0;
            len       = LEN_W'($urandom);
            tick;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        m_ov      = 1'b0;
        m_busy    = 1'b0;
    endtask

    task automatic set_pair(input int i, input int a, input int b);
        pa[i] = a & 16'hFFFF;
        pb[i] = b & 16'hFFFF;
    endtask

    task automatic chk_all_zero(input string nm);
        for (int k = 0; k < NCFG; k++) begin
            chk({nm, "_o"}, k, 32'(o_w[k]), 32'h0);
            chk({nm, "_out_valid"}, k, 32'(ov_w[k]), 32'h0);
            chk({nm, "_ovf"}, k, 32'(ovf_w[k]), 32'h0);
            chk({nm, "_in_ready"}, k, 32'(rdy_w[k]), 32'h0);
            chk({nm, "_busy"}, k, 32'(busy_w[k]), 32'h0);
        end
    endtask

    task automatic clear_model;
        m_busy   = 1'b0;
        m_acc    = 1'b0;
        m_ov     = 1'b0;
        m_issued = 0;
        m_len    = 0;
        for (int k = 0; k < NCFG; k++) m_o[k] = '0;
    endtask

    // Cycle-by-cycle comparison of every DUT against the model
    always @(negedge clk) begin
        if (running && !rst) begin
            for (int k = 0; k < NCFG; k++) begin
                chk("in_ready", k, 32'(rdy_w[k]), 32'(m_acc && (m_issued < m_len)));
                chk("busy", k, 32'(busy_w[k]), 32'(m_busy));
                chk("out_valid", k, 32'(ov_w[k]), 32'(m_ov));
                chk("o", k, 32'(o_w[k]), 32'(m_o[k]));
                if (m_ov) chk("ovf", k, 32'(ovf_w[k]), 32'(exp_ovf[k]));
            end
        end
    end

    initial begin
        clk = 1'b0; rst = 1'b0; start = 1'b0; len = '0; g_in = '0; e_in = '0;
        in_valid = 1'b0; out_ready = 1'b0; n_assert = 0; n_fail = 0; running = 1'b0;
        clear_model;
        #1 rst = 1'b1;
        #2 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        running = 1'b1;
        tick;

        // Small unsigned burst, back-to-back then with two-cycle gaps
        set_pair(0, 2, 3); set_pair(1, 4, 5); set_pair(2, 10, 10);
        for (int rep = 0; rep < 2; rep++) begin
            run_burst(3, rep * 2);
            chk("pin_126", 0, 32'(exp_res[0]), 32'd126);
            for (int k = 0; k < NCFG; k++) begin
                chk("t1_o", k, 32'(o_w[k]), 32'd126);
                chk("t1_ovf", k, 32'(ovf_w[k]), 32'd0);
            end
            take_result(1);
        end

        // Product overflow: wrap vs clamp
        set_pair(0, 300, 300); set_pair(1, 1, 1);
        run_burst(2, 0);
        chk("pin_5f91", 0, 32'(exp_res[0]), 32'h5F91);
        chk("t2_o", 0, 32'(o_w[0]), 32'h5F91);
        chk("t2_ovf", 0, 32'(ovf_w[0]), 32'd1);
        chk("t3_o", 2, 32'(o_w[2]), 32'hFFFF);
        chk("t3_ovf", 2, 32'(ovf_w[2]), 32'd1);
        chk("t3s_o", 3, 32'(o_w[3]), 32'h7FFF);
        take_result(2);

        // Sum overflow with in-range products
        set_pair(0, 40000, 1); set_pair(1, 40000, 1);
        run_burst(2, 1);
        chk("t3b_o", 2, 32'(o_w[2]), 32'hFFFF);
        chk("t3b_ovf", 2, 32'(ovf_w[2]), 32'd1);
        chk("t3b_wrap_o", 0, 32'(o_w[0]), 32'h3880);
        take_result(0);

        // Signed saturation at the negative bound, then an in-range signed burst
        set_pair(0, -200, 200); set_pair(1, -1, 1);
        run_burst(2, 0);
        chk("pin_8000", 3, 32'(exp_res[3]), 32'h8000);
        chk("t4_o", 3, 32'(o_w[3]), 32'h8000);
        chk("t4_ovf", 3, 32'(ovf_w[3]), 32'd1);
        take_result(1);
        set_pair(0, -3, 4); set_pair(1, 5, 2);
        run_burst(2, 1);
        chk("t4b_o", 3, 32'(o_w[3]), 32'hFFFE);
        chk("t4b_ovf", 3, 32'(ovf_w[3]), 32'd0);
        chk("t4b_wrap_o", 1, 32'(o_w[1]), 32'hFFFE);
        take_result(0);

        // Zero-length burst held in DONE with ignored start pulses
        run_burst(0, 0);
        for (int k = 0; k < NCFG; k++) chk("t5_o", k, 32'(o_w[k]), 32'd0);
        take_result(5);

        // Reset mid-burst aborts; the next burst is clean
        for (int i = 0; i < 4; i++) set_pair(i, 9, 9);
        start = 1'b1; len = LEN_W'(4);
        tick;
        start = 1'b0; m_busy = 1'b1; m_acc = 1'b1; m_len = 4; m_issued = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; g_in = 16'd9; e_in = 16'd9;
            tick;
            m_issued++;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        clear_model;
        #1 chk_all_zero("midrst");
        tick;
        rst = 1'b0;
        repeat (4) tick;
        set_pair(0, 7, 6);
        run_burst(1, 0);
        for (int k = 0; k < NCFG; k++) chk("t6_o", k, 32'(o_w[k]), 32'd42);
        take_result(0);

        // Randomised bursts
        for (int b = 0; b < 40; b++) begin
            int L = $urandom_range(0, 12);
            for (int i = 0; i < L; i++) begin
                int mode_a = $urandom_range(0, 2);
                int mode_b = $urandom_range(0, 2);
                pa[i] = (mode_a == 0) ? $urandom_range(0, 65535) :
                        (mode_a == 1) ? $urandom_range(0, 15) : 65536 - $urandom_range(1, 16);
                pb[i] = (mode_b == 0) ? $urandom_range(0, 65535) :
                        (mode_b == 1) ? $urandom_range(0, 15) : 65536 - $urandom_range(1, 16);
            end
            run_burst(L, $urandom_range(0, 2));
            take_result($urandom_range(0, 3));
            if ($urandom_range(0, 1) != 0) tick;
        end

        repeat (2) tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
